// File: rtl/vc_sw_alloc_rr_pkg.sv
// Shared types for the round-robin switch allocator: FSM state encoding.
// Optional packet statistics are enabled by defining ARB_STATS_EN (off by default).
package vc_sw_alloc_rr_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/vc_sw_alloc_rr_prio_pick.sv
// Combinational rotate-priority picker: first set request after i_low_pr (mod N),
// with i_low_pr itself checked last.
module rr_prio_pick #(
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input  logic [N-1:0]    i_req,
    input  logic [IDXW-1:0] i_low_pr,
    output logic            o_any,
    output logic [IDXW-1:0] o_win_idx,
    output logic [N-1:0]    o_win_oh
);

    logic [IDXW-1:0] w_pos;

    always_comb begin
        o_any     = 1'b0;
        o_win_idx = '0;
        o_win_oh  = '0;
        w_pos     = '0;
        // Scan farthest-first so the closest requester after the pointer overwrites last.
        for (int k = N; k >= 1; k--) begin
            w_pos = IDXW'((int'(i_low_pr) + k) % N);
            if (i_req[w_pos]) begin
                o_any     = 1'b1;
                o_win_idx = w_pos;
            end
        end
        o_win_oh[o_win_idx] = o_any;
    end

endmodule

// File: rtl/vc_sw_alloc_rr.sv
// Registered round-robin output-port allocator with wormhole lock until tail transfer.
// Define ARB_STATS_EN to add per-requester saturating packet counters on o_grant_cnt.
module vc_sw_alloc_rr
    import vc_sw_alloc_rr_pkg::*;
#(
    parameter int N     = 4,
    parameter int STATW = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [N-1:0]           i_req,
    input  logic [N-1:0]           i_tail,
    input  logic                   i_out_ready,
    output logic                   o_grant_vld,
    output logic [$clog2(N)-1:0]   o_grant_idx,
    output logic [N-1:0]           o_grant_oh,
    output logic                   o_fire
`ifdef ARB_STATS_EN
    ,output logic [N*STATW-1:0]    o_grant_cnt
`endif
);

    localparam int IDXW = $clog2(N);

    arb_state_e      r_state, w_state_nxt;
    logic [IDXW-1:0] r_low_pr, w_low_pr_nxt;
    logic [IDXW-1:0] r_grant_idx, w_idx_nxt;
    logic [N-1:0]    r_grant_oh, w_oh_nxt;

    logic            w_release;
    logic [IDXW-1:0] w_pick_ptr;
    logic            w_any;
    logic [IDXW-1:0] w_win_idx;
    logic [N-1:0]    w_win_oh;

    assign o_grant_vld = (r_state == ARB_LOCKED);
    assign o_grant_idx = r_grant_idx;
    assign o_grant_oh  = r_grant_oh;
    assign o_fire      = o_grant_vld & i_req[r_grant_idx] & i_out_ready;
    assign w_release   = o_fire & i_tail[r_grant_idx];

    // On tail release the finishing requester becomes lowest priority for the same-cycle re-pick.
    assign w_pick_ptr = w_release ? r_grant_idx : r_low_pr;

    rr_prio_pick #(.N(N), .IDXW(IDXW)) u_pick (
        .i_req     (i_req),
        .i_low_pr  (w_pick_ptr),
        .o_any     (w_any),
        .o_win_idx (w_win_idx),
        .o_win_oh  (w_win_oh)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_low_pr_nxt = r_low_pr;
        w_idx_nxt    = r_grant_idx;
        w_oh_nxt     = r_grant_oh;
        case (r_state)
            ARB_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ARB_LOCKED;
                    w_idx_nxt   = w_win_idx;
                    w_oh_nxt    = w_win_oh;
                end
            end
            ARB_LOCKED: begin
                if (w_release) begin
                    w_low_pr_nxt = r_grant_idx;
                    if (w_any) begin
                        w_idx_nxt = w_win_idx;
                        w_oh_nxt  = w_win_oh;
                    end else begin
                        w_state_nxt = ARB_IDLE;
                        w_oh_nxt    = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_oh_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ARB_IDLE;
            r_low_pr    <= IDXW'(N - 1);
            r_grant_idx <= '0;
            r_grant_oh  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_low_pr    <= w_low_pr_nxt;
            r_grant_idx <= w_idx_nxt;
            r_grant_oh  <= w_oh_nxt;
        end
    end

`ifdef ARB_STATS_EN
    logic [N-1:0][STATW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (w_release && (r_cnt[r_grant_idx] != {STATW{1'b1}})) begin
            r_cnt[r_grant_idx] <= r_cnt[r_grant_idx] + STATW'(1);
        end
    end

    assign o_grant_cnt = r_cnt;
`endif

endmodule
